// File: rtl/bf16_addsub_sched_if.sv
// Request/response bundle between the vector-lane front ends and the shared
// bf16 add/sub scheduler.
interface bf16_addsub_sched_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [16*N_REQ-1:0] req_a;
  logic [16*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_op;
  logic                resp_valid;
  logic                resp_ready;
  logic [ID_W-1:0]     resp_id;
  logic [15:0]         resp_result;
  logic [15:0]         issue_count;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, issue_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, issue_count
  );
endinterface

// File: rtl/bf16_addsub_sched.sv
// Round-robin scheduler sharing one combinational bf16 add/sub unit among
// N_REQ requesters: S1 issue register -> shared unit -> S2 response register.
module bf16_addsub_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  bf16_addsub_sched_if.slave bus
);
  localparam int unsigned DATA_W = 16;
  localparam logic [ID_W:0]   N_REQ_L = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              op;
    logic [ID_W-1:0]   id;
  } s1_t;

  // bf16 add/sub, round-to-nearest-even; subnormal inputs/results flush to zero
  function automatic logic [15:0] bf16_addsub(input logic [15:0] a,
                                              input logic [15:0] b,
                                              input logic        sub);
    logic [15:0]       bb, x, y;
    logic [7:0]        d;
    logic [10:0]       mx, my, ys, mask;
    logic [11:0]       sum;
    logic signed [9:0] e;
    logic [8:0]        mr;
    logic              rnd;
    bb = {b[15] ^ sub, b[14:0]};
    if ((a[14:7] == 8'hFF && a[6:0] != 7'd0) || (bb[14:7] == 8'hFF && bb[6:0] != 7'd0))
      return 16'h7FC0;
    if (a[14:7] == 8'hFF) begin
      if (bb[14:7] == 8'hFF && a[15] != bb[15]) return 16'h7FC0;
      return a;
    end
    if (bb[14:7] == 8'hFF) return bb;
    if (a[14:7] == 8'd0 && bb[14:7] == 8'd0) return {a[15] & bb[15], 15'd0};
    if (a[14:7] == 8'd0) return bb;
    if (bb[14:7] == 8'd0) return a;
    if (a[14:0] >= bb[14:0]) begin x = a;  y = bb; end
    else                     begin x = bb; y = a;  end
    d  = x[14:7] - y[14:7];
    mx = {1'b1, x[6:0], 3'b000};
    my = {1'b1, y[6:0], 3'b000};
    if (d >= 8'd11) begin
      ys = 11'd1;
    end else begin
      mask = (11'd1 << d) - 11'd1;
      ys   = (my >> d) | {10'd0, |(my & mask)};
    end
    if (x[15] == y[15]) sum = {1'b0, mx} + {1'b0, ys};
    else                sum = {1'b0, mx} - {1'b0, ys};
    if (sum == 12'd0) return 16'h0000;
    e = $signed({2'b00, x[14:7]});
    if (sum[11]) begin
      sum = {1'b0, sum[11:2], sum[1] | sum[0]};
      e   = e + 10'sd1;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (!sum[10]) begin
          sum = {sum[10:0], 1'b0};
          e   = e - 10'sd1;
        end
      end
    end
    rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
    mr  = {1'b0, sum[10:3]} + {8'd0, rnd};
    if (mr[8]) begin
      mr = {1'b0, mr[8:1]};
      e  = e + 10'sd1;
    end
    if (e <= 10'sd0)   return {x[15], 15'd0};
    if (e >= 10'sd255) return {x[15], 8'hFF, 7'd0};
    return {x[15], e[7:0], mr[6:0]};
  endfunction

  logic [ID_W-1:0]   rr_ptr;
  logic              s1_valid;
  s1_t               s1;
  logic [DATA_W-1:0] unit_result;
  logic              out_free, s1_adv, issue_ok, found, accept;
  logic [ID_W-1:0]   win, idx;
  logic [ID_W:0]     idx_sum;

  // Stall control
  always_comb begin
    out_free = !bus.resp_valid | bus.resp_ready;
    s1_adv   = s1_valid & out_free;
    issue_ok = !s1_valid | out_free;
  end

  // Round-robin search from rr_ptr, wrapping at N_REQ-1
  always_comb begin
    found   = 1'b0;
    win     = '0;
    idx     = '0;
    idx_sum = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx_sum >= N_REQ_L) idx_sum = idx_sum - N_REQ_L;
      idx = idx_sum[ID_W-1:0];
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    accept        = found & issue_ok & !rst;
    bus.req_ready = accept ? (N_REQ'(1) << win) : '0;
  end

  // Shared arithmetic unit, fed from the issue register
  always_comb unit_result = bf16_addsub(s1.a, s1.b, s1.op);

  // Issue stage, round-robin pointer and accept counter
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      s1              <= '0;
      rr_ptr          <= '0;
      bus.issue_count <= '0;
    end else if (accept) begin
      s1_valid        <= 1'b1;
      s1.a            <= bus.req_a[DATA_W*win +: DATA_W];
      s1.b            <= bus.req_b[DATA_W*win +: DATA_W];
      s1.op           <= bus.req_op[win];
      s1.id           <= win;
      rr_ptr          <= (win == LAST_ID) ? '0 : win + ID_W'(1);
      bus.issue_count <= bus.issue_count + 16'd1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Response register; fields hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= '0;
      bus.resp_result <= '0;
    end else if (s1_adv) begin
      bus.resp_valid  <= 1'b1;
      bus.resp_id     <= s1.id;
      bus.resp_result <= unit_result;
    end else if (bus.resp_ready && bus.resp_valid) begin
      bus.resp_valid <= 1'b0;
    end
  end
endmodule
